// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit word scheduler.
//   WORD_W            : width of a transmitted word
//   DEF_*             : default scheduler parameters
//   tx_state_e        : scheduler FSM state encoding
//   cnt_width()       : width of the frame/gap down-counter
package tx_sched_pkg;

    localparam int WORD_W           = 16;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_FRAME_CYCLES = 24;
    localparam int DEF_GAP_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // Must hold FRAME_CYCLES-1 and GAP_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int frame_cycles, input int gap_cycles);
        int m;
        m = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO for the transmit word scheduler.
// Ports:
//   clk_115200hz : clock, rising edge
//   reset        : asynchronous, active-high; empties the FIFO
//   push/in_data : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   head         : oldest stored word (valid when !empty)
//   level        : number of stored words, 0..DEPTH
//   full/empty   : level == DEPTH / level == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_115200hz,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the level, since the pointers are equal in both cases.
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_115200hz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only read through a valid head.
    always_ff @(posedge clk_115200hz) begin
        if (do_push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/tx_word_scheduler.sv
// Upstream feeder for the 16-bit serial transmitter. Queues words in a
// small FIFO and presents them one at a time: tx_start is held high for
// FRAME_CYCLES with tx_data stable, then low for GAP_CYCLES plus one IDLE
// cycle so the transmitter returns to its start state between words.
// Ports:
//   clk_115200hz : clock, rising edge
//   reset        : asynchronous, active-high; aborts any frame, drops queue
//   in_data      : word to queue (bit 0 transmitted first)
//   in_valid     : in_data valid; pushed when in_valid && in_ready
//   in_ready     : FIFO not full (combinational)
//   tx_data      : word presented to the transmitter (registered)
//   tx_start     : transmitter enable (registered)
//   busy         : frame or gap in progress, or words queued
//   fifo_level   : number of queued words
//   sent_count   : completed frames, wrapping 16-bit (only with macro)
// Build option: define TX_SCHED_WORD_COUNT_EN to add the sent_count port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | tx_start low; loads head word as soon as FIFO is non-empty
// SEND  | tx_start high, tx_data stable, counting FRAME_CYCLES
// GAP   | tx_start low, tx_data held, counting GAP_CYCLES
module tx_word_scheduler
    import tx_sched_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                     clk_115200hz,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_W-1:0]        tx_data,
    output logic                     tx_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef TX_SCHED_WORD_COUNT_EN
    ,
    output logic [15:0]              sent_count
`endif
);

    localparam int CNT_W = cnt_width(FRAME_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    tx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign in_ready = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign busy     = (state != IDLE) || !fifo_empty;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_115200hz (clk_115200hz),
        .reset        (reset),
        .push         (in_valid),
        .in_data      (in_data),
        .pop          (fifo_pop),
        .head         (fifo_head),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    always_ff @(posedge clk_115200hz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_data  <= fifo_head;
                        tx_start <= 1'b1;
                        cnt      <= FRAME_LOAD;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == '0) begin
                        tx_start <= 1'b0;
                        cnt      <= GAP_LOAD;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_SCHED_WORD_COUNT_EN
    logic [15:0] sent_count_q;

    // Counts completed frames; an aborted frame (reset mid-SEND) is not counted.
    always_ff @(posedge clk_115200hz or posedge reset) begin
        if (reset) begin
            sent_count_q <= '0;
        end else if (state == SEND && cnt == '0) begin
            sent_count_q <= sent_count_q + 16'd1;
        end
    end

    assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Scoreboard bench for tx_word_scheduler: the driver pushes expected words
// into a queue as they are accepted; a negedge monitor pops and compares on
// every tx_start rising edge and checks frame length, gap and stability.
module tb_tx_word_scheduler;

    localparam int DEPTH = 4;
    localparam int FRAME = 24;
    localparam int PERIOD = 27;

    logic        clk_115200hz = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        busy;
    logic [2:0]  fifo_level;
`ifdef TX_SCHED_WORD_COUNT_EN
    logic [15:0] sent_count;
`endif

    tx_word_scheduler dut (
        .clk_115200hz (clk_115200hz),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .busy         (busy),
        .fifo_level   (fifo_level)
`ifdef TX_SCHED_WORD_COUNT_EN
        ,
        .sent_count   (sent_count)
`endif
    );

    always #5 clk_115200hz = ~clk_115200hz;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_level = 0;
    int last_push_cyc = 0;
    logic [15:0] sb[$];
    int rise_q[$];

    always @(posedge clk_115200hz) cyc++;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    logic        prev_start = 1'b0;
    logic        had_frame  = 1'b0;
    logic        stable     = 1'b1;
    logic [15:0] cur_word   = '0;
    int          hi_cnt     = 0;
    int          low_cnt    = 0;

    always @(negedge clk_115200hz) begin
        if (reset) begin
            prev_start = 1'b0;
            had_frame  = 1'b0;
            hi_cnt     = 0;
            low_cnt    = 0;
        end else begin
            if (tx_start && !prev_start) begin
                rise_q.push_back(cyc);
                if (sb.size() == 0) begin
                    check_eq("unexpected_frame", {16'd0, tx_data}, 32'hDEAD_0000);
                end else begin
                    check_eq("frame_word", {16'd0, tx_data}, {16'd0, sb.pop_front()});
                    model_level--;
                end
                if (had_frame) check_eq("gap_ge_3", {31'd0, (low_cnt >= 3)}, 32'd1);
                cur_word = tx_data;
                stable   = 1'b1;
                hi_cnt   = 1;
            end else if (tx_start) begin
                hi_cnt++;
                if (tx_data !== cur_word) stable = 1'b0;
            end else if (prev_start) begin
                check_eq("frame_len", hi_cnt, FRAME);
                check_eq("frame_stable", {31'd0, stable}, 32'd1);
                had_frame = 1'b1;
                low_cnt   = 1;
            end else begin
                low_cnt++;
            end
            prev_start = tx_start;
        end
    end

    task automatic push_word(input logic [15:0] w);
        logic exp_acc;
        @(negedge clk_115200hz); #1;
        in_data  = w;
        in_valid = 1'b1;
        exp_acc  = (model_level < DEPTH);
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
        check_eq("fifo_level", {29'd0, fifo_level}, model_level);
        @(posedge clk_115200hz); #1;
        if (exp_acc) begin
            sb.push_back(w);
            model_level++;
            last_push_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
            @(negedge clk_115200hz);
            n++;
        end
        check_eq("drain_in_time", {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk_115200hz);
        @(negedge clk_115200hz);
        reset = 1'b0;

        // Reset state held through idle cycles
        repeat (10) @(negedge clk_115200hz);
        check_eq("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_eq("rst_tx_data", {16'd0, tx_data}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_fifo_level", {29'd0, fifo_level}, 32'd0);

        // Single word: latency, busy, idle return
        rise_q.delete();
        push_word(16'hA55A);
        base = last_push_cyc;
        n = 0;
        while (rise_q.size() == 0 && n < 10) begin
            @(negedge clk_115200hz);
            n++;
        end
        check_eq("first_rise_seen", {31'd0, (rise_q.size() == 1)}, 32'd1);
        if (rise_q.size() > 0) check_eq("start_latency", rise_q[0] - base, 32'd1);
        check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk_115200hz);
            n++;
        end
        check_eq("busy_fall_cycle", cyc - base, PERIOD);

        // Fill to full, hold a rejected word, then check order and spacing
        rise_q.delete();
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        push_word(16'h0004);
        push_word(16'h0005);
        check_eq("full_level", model_level, DEPTH);
        repeat (10) push_word(16'hFFFF);
        wait_drain(400);
        check_eq("frames_sent", rise_q.size(), 32'd5);
        for (int i = 1; i < rise_q.size(); i++)
            check_eq("frame_period", rise_q[i] - rise_q[i-1], PERIOD);
        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-SEND with two words queued
        rise_q.delete();
        push_word(16'h1234);
        push_word(16'hBEEF);
        push_word(16'hCAFE);
        n = 0;
        while (rise_q.size() == 0 && n < 10) begin
            @(negedge clk_115200hz);
            n++;
        end
        check_eq("abort_frame_started", rise_q.size(), 32'd1);
        check_eq("abort_level_before", {29'd0, fifo_level}, 32'd2);
        repeat (10) @(negedge clk_115200hz);
        #2;
        reset = 1'b1;
        sb.delete();
        model_level = 0;
        #1;
        check_eq("abort_tx_start", {31'd0, tx_start}, 32'd0);
        check_eq("abort_fifo_level", {29'd0, fifo_level}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_115200hz); #2;
        reset = 1'b0;
        repeat (80) @(negedge clk_115200hz);
        check_eq("abort_no_more_frames", rise_q.size(), 32'd1);
        check_eq("abort_tx_start_idle", {31'd0, tx_start}, 32'd0);

`ifdef TX_SCHED_WORD_COUNT_EN
        check_eq("cnt_after_reset", {16'd0, sent_count}, 32'd0);
        push_word(16'h0A0A);
        push_word(16'h0B0B);
        push_word(16'h0C0C);
        wait_drain(400);
        check_eq("cnt_three", {16'd0, sent_count}, 32'd3);
        @(negedge clk_115200hz);
        force dut.sent_count_q = 16'hFFFF;
        #1;
        release dut.sent_count_q;
        push_word(16'h0D0D);
        wait_drain(200);
        check_eq("cnt_wrap", {16'd0, sent_count}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
